// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the RV32 memory-access stage.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} lsu_state_e;
  typedef enum logic [1:0] {NONE, LOAD, STORE} mem_kind_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, legality check,
// and load-data alignment with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        err,
  input  logic [2:0]  rd_funct3,
  input  logic [1:0]  rd_offset,
  input  logic [31:0] rdata,
  output logic [31:0] rd_data
);

  logic [31:0] shifted;

  // Unsigned funct3 codes are loads only, so a store using them is illegal.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    err       = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        err       = store && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        be        = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        err       = offset[0] || (store && (funct3 == F3_HU));
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        err       = |offset;
      end
      default: err = 1'b1;
    endcase
    if (load && store) err = 1'b1;
  end

  assign shifted = rdata >> {rd_offset, 3'b000};

  always_comb begin
    rd_data = '0;
    case (rd_funct3)
      F3_B:    rd_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rd_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rd_data = shifted;
      F3_BU:   rd_data = {24'b0, shifted[7:0]};
      F3_HU:   rd_data = {16'b0, shifted[15:0]};
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// RV32 memory-access stage: issues data-memory accesses over req/gnt/rvalid
// and hands load data / ALU result to writeback. Optional: LSU_TIMEOUT_EN.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
)
(
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             valid_in,
  input  logic             load_in,
  input  logic             store_in,
  input  logic [2:0]       funct3_in,
  input  logic [WIDTH-1:0] alu_res_in,
  input  logic [WIDTH-1:0] wdata_in,
  output logic             stall_out,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic [WIDTH-1:0] mem_addr_out,
  output logic [3:0]       mem_be_out,
  output logic [WIDTH-1:0] mem_wdata_out,
  input  logic             mem_gnt_in,
  input  logic             mem_rvalid_in,
  input  logic [WIDTH-1:0] mem_rdata_in,
  output logic             valid_out,
  output logic             sel_out,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] alu_res_out,
  output logic             err_out
);

  lsu_state_e       state, state_next;
  mem_kind_e        kind;
  logic [WIDTH-1:0] addr_q, wdata_q, alu_q;
  logic [3:0]       be_q, be;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [WIDTH-1:0] wdata_rep, rd_data;
  logic             align_err, timeout;
  logic             accept_mem, done, done_err, done_sel, done_load;

  lsu_align u_align (
    .load      (load_in),
    .store     (store_in),
    .funct3    (funct3_in),
    .offset    (alu_res_in[1:0]),
    .wdata     (wdata_in),
    .be        (be),
    .wdata_rep (wdata_rep),
    .err       (align_err),
    .rd_funct3 (f3_q),
    .rd_offset (off_q),
    .rdata     (mem_rdata_in),
    .rd_data   (rd_data)
  );

  assign stall_out     = (state != IDLE);
  assign mem_req_out   = (state == REQ);
  assign mem_we_out    = mem_req_out && (kind == STORE);
  assign mem_addr_out  = addr_q;
  assign mem_be_out    = be_q;
  assign mem_wdata_out = wdata_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;

  // Restarts on every state change so REQ and WAIT_R each get a full budget.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)               tmo_cnt <= '0;
    else if (state_next != state) tmo_cnt <= '0;
    else if (state != IDLE)       tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state != IDLE) && (tmo_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0 && (TIMEOUT > 0);
`endif

  always_comb begin
    state_next = state;
    accept_mem = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    done_sel   = 1'b1;
    done_load  = 1'b0;
    case (state)
      IDLE: if (valid_in) begin
        if (!load_in && !store_in) begin
          done = 1'b1;
        end else if (align_err) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          accept_mem = 1'b1;
          state_next = REQ;
        end
      end
      REQ: if (mem_gnt_in) begin
        if (kind == STORE) begin
          state_next = IDLE;
          done       = 1'b1;
        end else begin
          state_next = WAIT_R;
        end
      end else if (timeout) begin
        state_next = IDLE;
        done       = 1'b1;
        done_err   = 1'b1;
      end
      WAIT_R: if (mem_rvalid_in) begin
        state_next = IDLE;
        done       = 1'b1;
        done_load  = 1'b1;
        done_sel   = 1'b0;
      end else if (timeout) begin
        state_next = IDLE;
        done       = 1'b1;
        done_err   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results go out only with the completion pulse, so they hold in between.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      kind        <= NONE;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      off_q       <= '0;
      alu_q       <= '0;
      valid_out   <= 1'b0;
      sel_out     <= 1'b1;
      err_out     <= 1'b0;
      data_out    <= '0;
      alu_res_out <= '0;
    end else begin
      state     <= state_next;
      valid_out <= done;
      if (accept_mem) begin
        kind    <= load_in ? LOAD : STORE;
        addr_q  <= {alu_res_in[WIDTH-1:2], 2'b00};
        be_q    <= be;
        wdata_q <= wdata_rep;
        f3_q    <= funct3_in;
        off_q   <= alu_res_in[1:0];
        alu_q   <= alu_res_in;
      end
      if (done) begin
        sel_out     <= done_sel;
        err_out     <= done_err;
        alu_res_out <= (state == IDLE) ? alu_res_in : alu_q;
        if (done_err)       data_out <= '0;
        else if (done_load) data_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu; the bench plays the data memory and
// predicts every result from the ISA load/store rules. Optional: LSU_TIMEOUT_EN.
module tb_mem_lsu;

  localparam int TMO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam int MAXD = TMO - 1;
`else
  localparam int MAXD = 5;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        valid_in = 1'b0, load_in = 1'b0, store_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] alu_res_in = '0, wdata_in = '0;
  logic        stall_out, mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic        mem_gnt_in = 1'b0, mem_rvalid_in = 1'b0;
  logic [31:0] mem_rdata_in = '0;
  logic        valid_out, sel_out, err_out;
  logic [31:0] data_out, alu_res_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  mem_lsu #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .load_in(load_in),
    .store_in(store_in), .funct3_in(funct3_in), .alu_res_in(alu_res_in),
    .wdata_in(wdata_in), .stall_out(stall_out), .mem_req_out(mem_req_out),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_be_out(mem_be_out),
    .mem_wdata_out(mem_wdata_out), .mem_gnt_in(mem_gnt_in),
    .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
    .valid_out(valid_out), .sel_out(sel_out), .data_out(data_out),
    .alu_res_out(alu_res_out), .err_out(err_out)
  );

  // Reference model: access size in bytes, legality, lanes and load result.
  function automatic int sizeBytes(input logic [2:0] f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit isLegal(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] addr);
    if (ld && st) return 0;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
    if (st && f3 > 3'd2) return 0;
    return (addr % sizeBytes(f3)) == 0;
  endfunction

  function automatic logic [31:0] expBe(input logic [2:0] f3, input logic [31:0] addr);
    return (((1 << sizeBytes(f3)) - 1) << (addr % 4)) & 15;
  endfunction

  function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] wd);
    case (sizeBytes(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (addr % 4));
    case (f3)
      3'd0:    return (v & 32'hFF) + (((v & 32'h80) != 0) ? 32'hFFFF_FF00 : 32'h0);
      3'd1:    return (v & 32'hFFFF) + (((v & 32'h8000) != 0) ? 32'hFFFF_0000 : 32'h0);
      3'd2:    return rd;
      3'd4:    return v & 32'hFF;
      default: return v & 32'hFFFF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one instruction, then answers as memory with the given delays.
  // Entered and left just after a rising edge with the DUT idle.
  task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input int gnt_delay,
                               input int rv_delay);
    bit legal;
    legal = isLegal(ld, st, f3, addr);
    valid_in = 1'b1; load_in = ld; store_in = st;
    funct3_in = f3; alu_res_in = addr; wdata_in = wd;
    @(negedge clk_in);
    checkOutput("stall_idle", 32'(stall_out), 0);
    @(posedge clk_in); #1;
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
    funct3_in = 3'($urandom); alu_res_in = $urandom; wdata_in = $urandom;
    if (!(ld || st) || !legal) begin
      @(negedge clk_in);
      checkOutput("direct_valid", 32'(valid_out), 1);
      checkOutput("direct_err", 32'(err_out), 32'(ld || st));
      checkOutput("direct_alu", alu_res_out, addr);
      checkOutput("direct_noreq", 32'(mem_req_out), 0);
      checkOutput("direct_stall", 32'(stall_out), 0);
      if (!(ld || st)) checkOutput("direct_sel", 32'(sel_out), 1);
      else             checkOutput("err_data", data_out, 0);
    end else begin
      for (int d = 0; d <= gnt_delay; d++) begin
        mem_gnt_in    = (d == gnt_delay);
        mem_rvalid_in = (d == gnt_delay) && ld;
        mem_rdata_in  = $urandom;
        @(negedge clk_in);
        checkOutput("req", 32'(mem_req_out), 1);
        checkOutput("req_stall", 32'(stall_out), 1);
        checkOutput("req_valid", 32'(valid_out), 0);
        checkOutput("req_addr", mem_addr_out, addr & 32'hFFFF_FFFC);
        checkOutput("req_be", 32'(mem_be_out), expBe(f3, addr));
        checkOutput("req_we", 32'(mem_we_out), 32'(st));
        if (st) checkOutput("req_wdata", mem_wdata_out, expWdata(f3, wd));
        @(posedge clk_in); #1;
      end
      mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0;
      if (ld) begin
        for (int d = 0; d <= rv_delay; d++) begin
          mem_rvalid_in = (d == rv_delay);
          mem_rdata_in  = (d == rv_delay) ? rd : $urandom;
          @(negedge clk_in);
          checkOutput("wait_stall", 32'(stall_out), 1);
          checkOutput("wait_noreq", 32'(mem_req_out), 0);
          checkOutput("wait_valid", 32'(valid_out), 0);
          @(posedge clk_in); #1;
        end
        mem_rvalid_in = 1'b0;
      end
      @(negedge clk_in);
      checkOutput("done_valid", 32'(valid_out), 1);
      checkOutput("done_err", 32'(err_out), 0);
      checkOutput("done_sel", 32'(sel_out), 32'(!ld));
      checkOutput("done_alu", alu_res_out, addr);
      checkOutput("done_stall", 32'(stall_out), 0);
      if (ld) checkOutput("load_data", data_out, expLoad(f3, addr, rd));
    end
    @(posedge clk_in); #1;
    @(negedge clk_in);
    checkOutput("valid_pulse", 32'(valid_out), 0);
    @(posedge clk_in); #1;
  endtask

  initial begin
    bit ld, st;
    logic [2:0]  f3;
    logic [31:0] addr;

    #12;
    checkOutput("rst_valid", 32'(valid_out), 0);
    checkOutput("rst_sel", 32'(sel_out), 1);
    checkOutput("rst_req", 32'(mem_req_out), 0);
    checkOutput("rst_stall", 32'(stall_out), 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_alu", alu_res_out, 0);
    checkOutput("rst_err", 32'(err_out), 0);
    @(negedge clk_in); rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    applyStimulus(0, 0, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 1, 3'b000, 32'h103, 32'hAABBCCDD, 32'h0, 3, 0);
    applyStimulus(1, 0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0, 0);
    applyStimulus(1, 0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 1, 2);
    applyStimulus(1, 0, 3'b001, 32'h201, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 3'b011, 32'h200, 32'h0, 32'h0, 0, 0);
    applyStimulus(1, 1, 3'b010, 32'h200, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 1, 3'b100, 32'h200, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 1, 3'b001, 32'h302, 32'h12345678, 32'h0, 0, 0);
    applyStimulus(1, 0, 3'b101, 32'h306, 32'h0, 32'h8001_7FFF, 2, 0);

    // Reset during WAIT_R, followed by a stray rvalid.
    valid_in = 1'b1; load_in = 1'b1; funct3_in = 3'b010; alu_res_in = 32'h300;
    @(posedge clk_in); #1;
    valid_in = 1'b0; load_in = 1'b0; mem_gnt_in = 1'b1;
    @(posedge clk_in); #1;
    mem_gnt_in = 1'b0;
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(mem_req_out), 0);
    checkOutput("midrst_stall", 32'(stall_out), 0);
    @(negedge clk_in); rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    mem_rvalid_in = 1'b1; mem_rdata_in = 32'hDEAD_BEEF;
    @(negedge clk_in);
    checkOutput("stray_valid", 32'(valid_out), 0);
    checkOutput("stray_stall", 32'(stall_out), 0);
    checkOutput("stray_req", 32'(mem_req_out), 0);
    @(posedge clk_in); #1;
    mem_rvalid_in = 1'b0;
    @(negedge clk_in);
    checkOutput("stray_valid2", 32'(valid_out), 0);
    @(posedge clk_in); #1;

`ifdef LSU_TIMEOUT_EN
    // Store never granted: request drops after TMO cycles with an error.
    valid_in = 1'b1; store_in = 1'b1; funct3_in = 3'b010; alu_res_in = 32'h40;
    @(posedge clk_in); #1;
    valid_in = 1'b0; store_in = 1'b0;
    for (int d = 0; d < TMO; d++) begin
      @(negedge clk_in);
      checkOutput("tmo_req", 32'(mem_req_out), 1);
      @(posedge clk_in); #1;
    end
    @(negedge clk_in);
    checkOutput("tmo_req_drop", 32'(mem_req_out), 0);
    checkOutput("tmo_valid", 32'(valid_out), 1);
    checkOutput("tmo_err", 32'(err_out), 1);
    checkOutput("tmo_data", data_out, 0);
    @(posedge clk_in); #1;
    // Load granted but rvalid never arrives.
    valid_in = 1'b1; load_in = 1'b1; funct3_in = 3'b010; alu_res_in = 32'h44;
    @(posedge clk_in); #1;
    valid_in = 1'b0; load_in = 1'b0; mem_gnt_in = 1'b1;
    @(posedge clk_in); #1;
    mem_gnt_in = 1'b0;
    for (int d = 0; d < TMO; d++) begin
      @(negedge clk_in);
      checkOutput("tmo_wait", 32'(stall_out), 1);
      @(posedge clk_in); #1;
    end
    @(negedge clk_in);
    checkOutput("tmo_rd_valid", 32'(valid_out), 1);
    checkOutput("tmo_rd_err", 32'(err_out), 1);
    @(posedge clk_in); #1;
    applyStimulus(0, 1, 3'b010, 32'h48, 32'h5555AAAA, 32'h0, TMO - 1, 0);
    applyStimulus(1, 0, 3'b000, 32'h49, 32'h0, 32'h0000_7F00, 0, TMO - 1);
`endif

    for (int i = 0; i < 150; i++) begin
      ld   = 1'b0;
      st   = 1'b0;
      case ($urandom_range(0, 9))
        0:       ;
        1:       begin ld = 1'b1; st = 1'b1; end
        2, 3, 4, 5: ld = 1'b1;
        default: st = 1'b1;
      endcase
      f3   = 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(sizeBytes(f3)) - 1);
      applyStimulus(ld, st, f3, addr, $urandom, $urandom,
                    $urandom_range(0, MAXD), $urandom_range(0, MAXD));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
